// File: rtl/adc_scan.sv
// adc_scan: register-mapped scan controller for an 8-channel ADC macro.
//   Walks the channels set in CTRL.mask (low to high). For each channel it
//   drives the channel select, waits a mux settle time, pulses SOC, waits for
//   end-of-conversion and stores the sample in that channel's RESULT register.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_ribs_*/o_ribs_*      RIB slave: gnt = req, rsp/rdata one cycle after req
//   o_adc_s, o_adc_soc     channel select and start-of-conversion to the ADC
//   i_adc_eoc, i_adc_dout  end-of-conversion (asynchronous) and sample
//
// Map: 0x00 CTRL {mask[15:8], CONT[1], EN[0]}
//      0x04 STATUS {OVR[2] w1c, DONE[1] w1c, BUSY[0] ro}
//      0x20+4n RESULT n {FRESH[31], data[11:0]}, reading clears FRESH
//
// Optional feature: define ADC_SCAN_AVG_EN to convert every channel four times
// back-to-back and store the average (sum[13:2]) instead of a single sample.
module adc_scan #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SOC_CYCLES    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ribs_addr,
  input  logic        i_ribs_wrcs,
  input  logic [3:0]  i_ribs_mask,
  input  logic [31:0] i_ribs_wdata,
  output logic [31:0] o_ribs_rdata,
  input  logic        i_ribs_req,
  output logic        o_ribs_gnt,
  output logic        o_ribs_rsp,
  input  logic        i_ribs_rdy,
  output logic [2:0]  o_adc_s,
  output logic        o_adc_soc,
  input  logic        i_adc_eoc,
  input  logic [11:0] i_adc_dout
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SOC, S_WAIT, S_STORE} state_t;

  state_t           state, state_nx;
  logic             ctrl_en, ctrl_cont;
  logic [7:0]       ctrl_mask;
  logic             st_done, st_ovr;
  logic [7:0][11:0] res_data;
  logic [7:0]       res_fresh;
  logic             eoc_meta, eoc_sync, eoc_prev, eoc_rise;
  logic [7:0]       cnt;
  logic [2:0]       ch_nx, lo_ch, nx_ch;
  logic             has_nx, set_done, clr_en, last_smp, store;
  logic [11:0]      res_val;
  logic [31:0]      rd_val;

`ifdef ADC_SCAN_AVG_EN
  logic [13:0] acc;
  logic [1:0]  smp_cnt;
  assign last_smp = (smp_cnt == 2'd3);
  assign res_val  = acc[13:2];
`else
  logic [11:0] acc;
  assign last_smp = 1'b1;
  assign res_val  = acc;
`endif

  // bus decode
  logic [7:0] a;
  logic       wr, rd, is_res, wr_ctrl, wr_stat, rd_res;
  logic [2:0] res_idx;
  assign a          = i_ribs_addr[7:0];
  assign wr         = i_ribs_req & i_ribs_wrcs;
  assign rd         = i_ribs_req & ~i_ribs_wrcs;
  assign is_res     = (a[7:5] == 3'b001) && (a[1:0] == 2'b00);
  assign res_idx    = a[4:2];
  assign wr_ctrl    = wr && (a == 8'h00);
  assign wr_stat    = wr && (a == 8'h04) && i_ribs_mask[0];
  assign rd_res     = rd && is_res;
  assign store      = (state == S_STORE);
  assign eoc_rise   = eoc_sync & ~eoc_prev;
  assign o_ribs_gnt = i_ribs_req;

  // responses are unconditional one cycle after req, so rdy is not consulted
  logic unused_bits;
  assign unused_bits = ^{i_ribs_rdy, i_ribs_addr[31:8], i_ribs_mask[3:2],
                         i_ribs_wdata[31:16], i_ribs_wdata[7:3]};

  // channel pick: lowest set mask bit, and next set bit above the current one
  always_comb begin
    lo_ch  = '0;
    nx_ch  = '0;
    has_nx = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (ctrl_mask[i]) lo_ch = 3'(i);
      if (ctrl_mask[i] && (i > int'(o_adc_s))) begin
        nx_ch  = 3'(i);
        has_nx = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = o_adc_s;
    set_done = 1'b0;
    clr_en   = 1'b0;
    case (state)
      S_IDLE:   if (ctrl_en && (ctrl_mask != 8'h00)) begin
                  state_nx = S_SETTLE;
                  ch_nx    = lo_ch;
                end
      S_SETTLE: if (cnt == 8'(SETTLE_CYCLES - 1)) state_nx = S_SOC;
      S_SOC:    if (cnt == 8'(SOC_CYCLES - 1)) state_nx = S_WAIT;
      S_WAIT:   if (eoc_rise) state_nx = last_smp ? S_STORE : S_SOC;
      S_STORE: begin
        if (!ctrl_en) begin
          state_nx = S_IDLE;
        end else if (has_nx) begin
          state_nx = S_SETTLE;
          ch_nx    = nx_ch;
        end else begin
          set_done = 1'b1;
          if (ctrl_cont && (ctrl_mask != 8'h00)) begin
            state_nx = S_SETTLE;
            ch_nx    = lo_ch;
          end else begin
            // a single scan drops EN so IDLE does not immediately rescan
            state_nx = S_IDLE;
            clr_en   = 1'b1;
          end
        end
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (a == 8'h00)      rd_val = {16'h0, ctrl_mask, 6'h0, ctrl_cont, ctrl_en};
    else if (a == 8'h04) rd_val = {29'h0, st_ovr, st_done, (state != S_IDLE)};
    else if (is_res)     rd_val = {res_fresh[res_idx], 19'h0, res_data[res_idx]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      o_adc_s      <= '0;
      o_adc_soc    <= 1'b0;
      cnt          <= '0;
      eoc_meta     <= 1'b0;
      eoc_sync     <= 1'b0;
      eoc_prev     <= 1'b0;
      acc          <= '0;
`ifdef ADC_SCAN_AVG_EN
      smp_cnt      <= '0;
`endif
      ctrl_en      <= 1'b0;
      ctrl_cont    <= 1'b0;
      ctrl_mask    <= '0;
      st_done      <= 1'b0;
      st_ovr       <= 1'b0;
      res_data     <= '0;
      res_fresh    <= '0;
      o_ribs_rsp   <= 1'b0;
      o_ribs_rdata <= '0;
    end else begin
      state     <= state_nx;
      o_adc_s   <= ch_nx;
      o_adc_soc <= (state_nx == S_SOC);
      eoc_meta  <= i_adc_eoc;
      eoc_sync  <= eoc_meta;
      eoc_prev  <= eoc_sync;

      if (state_nx != state) cnt <= '0;
      else if ((state == S_SETTLE) || (state == S_SOC)) cnt <= cnt + 8'd1;

      // accumulator restarts on every channel entry
      if ((state != S_SETTLE) && (state_nx == S_SETTLE)) begin
        acc <= '0;
`ifdef ADC_SCAN_AVG_EN
        smp_cnt <= '0;
`endif
      end else if ((state == S_WAIT) && eoc_rise) begin
`ifdef ADC_SCAN_AVG_EN
        acc     <= acc + 14'(i_adc_dout);
        smp_cnt <= smp_cnt + 2'd1;
`else
        acc     <= i_adc_dout;
`endif
      end

      // host write after auto-clear so a concurrent EN write is kept
      if (clr_en) ctrl_en <= 1'b0;
      if (wr_ctrl) begin
        if (i_ribs_mask[0]) begin
          ctrl_en   <= i_ribs_wdata[0];
          ctrl_cont <= i_ribs_wdata[1];
        end
        if (i_ribs_mask[1]) ctrl_mask <= i_ribs_wdata[15:8];
      end

      if (set_done) st_done <= 1'b1;
      else if (wr_stat && i_ribs_wdata[1]) st_done <= 1'b0;

      if (store && res_fresh[o_adc_s]) st_ovr <= 1'b1;
      else if (wr_stat && i_ribs_wdata[2]) st_ovr <= 1'b0;

      for (int n = 0; n < 8; n++) begin
        if (store && (o_adc_s == 3'(n))) begin
          res_data[n]  <= res_val;
          res_fresh[n] <= 1'b1;
        end else if (rd_res && (res_idx == 3'(n))) begin
          res_fresh[n] <= 1'b0;
        end
      end

      o_ribs_rsp   <= i_ribs_req;
      o_ribs_rdata <= rd ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_adc_scan.sv
// Directed bench for adc_scan with a behavioural ADC model: each SOC rising
// edge schedules an EOC pulse ADC_DLY cycles later carrying the next queued
// sample (or a default value when the queue is empty).
module tb_adc_scan;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_ribs_addr = '0;
  logic        i_ribs_wrcs = 1'b0;
  logic [3:0]  i_ribs_mask = '0;
  logic [31:0] i_ribs_wdata = '0;
  logic [31:0] o_ribs_rdata;
  logic        i_ribs_req = 1'b0;
  logic        o_ribs_gnt;
  logic        o_ribs_rsp;
  logic        i_ribs_rdy = 1'b1;
  logic [2:0]  o_adc_s;
  logic        o_adc_soc;
  logic        i_adc_eoc = 1'b0;
  logic [11:0] i_adc_dout = '0;

`ifdef ADC_SCAN_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif
  localparam int ADC_DLY = 10;

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  int soc_pulses = 0;
  int soc_hi = 0;
  int soc_rise_cyc = 0;
  int cd = 0;
  int eoc_hold = 0;
  logic soc_q = 1'b0;
  logic [2:0]  s_log[$];
  logic [11:0] samples[$];
  logic last_rsp;

  adc_scan #(.SETTLE_CYCLES(4), .SOC_CYCLES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ribs_addr(i_ribs_addr), .i_ribs_wrcs(i_ribs_wrcs), .i_ribs_mask(i_ribs_mask),
    .i_ribs_wdata(i_ribs_wdata), .o_ribs_rdata(o_ribs_rdata),
    .i_ribs_req(i_ribs_req), .o_ribs_gnt(o_ribs_gnt), .o_ribs_rsp(o_ribs_rsp),
    .i_ribs_rdy(i_ribs_rdy),
    .o_adc_s(o_adc_s), .o_adc_soc(o_adc_soc), .i_adc_eoc(i_adc_eoc), .i_adc_dout(i_adc_dout)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ADC model, evaluated away from the active edge
  always @(negedge i_clk) begin
    soc_q <= o_adc_soc;
    if (o_adc_soc) soc_hi <= soc_hi + 1;
    if (o_adc_soc && !soc_q) begin
      soc_pulses   <= soc_pulses + 1;
      soc_rise_cyc <= cyc;
      s_log.push_back(o_adc_s);
      cd <= ADC_DLY;
    end else if (cd > 1) begin
      cd <= cd - 1;
    end else if (cd == 1) begin
      cd <= 0;
      i_adc_eoc <= 1'b1;
      eoc_hold  <= 3;
      if (samples.size() > 0) i_adc_dout <= samples.pop_front();
      else                    i_adc_dout <= 12'h3C3;
    end
    if (eoc_hold == 1) i_adc_eoc <= 1'b0;
    if (eoc_hold > 0)  eoc_hold <= eoc_hold - 1;
  end

  task automatic rib_wr(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] m);
    @(negedge i_clk);
    i_ribs_req = 1'b1; i_ribs_wrcs = 1'b1; i_ribs_addr = {24'h0, ad};
    i_ribs_wdata = d; i_ribs_mask = m;
    @(negedge i_clk);
    i_ribs_req = 1'b0; i_ribs_wrcs = 1'b0;
  endtask

  task automatic rib_rd(input logic [7:0] ad, output logic [31:0] d);
    @(negedge i_clk);
    i_ribs_req = 1'b1; i_ribs_wrcs = 1'b0; i_ribs_addr = {24'h0, ad};
    @(negedge i_clk);
    i_ribs_req = 1'b0;
    d = o_ribs_rdata;
    last_rsp = o_ribs_rsp;
  endtask

  // polls STATUS.BUSY until clear; to=1 if the bound expires
  task automatic wait_idle(input int max_polls, output bit to);
    logic [31:0] d;
    to = 1'b1;
    repeat (4) @(negedge i_clk);
    for (int i = 0; i < max_polls; i++) begin
      rib_rd(8'h04, d);
      if (d[0] == 1'b0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_adc_soc, o_adc_s, o_ribs_rsp} !== 5'b0) begin
      errs++; $display("FAIL reset_outputs: got %b expected 00000", {o_adc_soc, o_adc_s, o_ribs_rsp});
    end
    checks++;
    if (o_ribs_rdata !== 32'h0) begin
      errs++; $display("FAIL reset_rdata: got %h expected 00000000", o_ribs_rdata);
    end
    i_rst = 1'b0;
    rib_rd(8'h04, d);
    checks++;
    if (last_rsp !== 1'b1) begin
      errs++; $display("FAIL rsp_after_req: got %b expected 1", last_rsp);
    end
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL reset_status: got %h expected 00000000", d);
    end
    @(negedge i_clk);
    checks++;
    if (o_ribs_rsp !== 1'b0) begin
      errs++; $display("FAIL rsp_idle: got %b expected 0", o_ribs_rsp);
    end
    rib_rd(8'h20, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL reset_result0: got %h expected 00000000", d);
    end
  endtask

  task automatic test_single_channel();
    logic [31:0] d;
    int p0, h0, t0;
    bit to;
    repeat (NS) samples.push_back(12'hABC);
    p0 = soc_pulses; h0 = soc_hi;
    rib_wr(8'h00, 32'h0000_0101, 4'hF);
    t0 = cyc;
    wait_idle(100, to);
    checks++;
    if (to) begin
      errs++; $display("FAIL single_timeout: busy never cleared");
    end
    checks++;
    if (soc_rise_cyc - t0 - (NS - 1) * 0 !== 5 && NS == 1) begin
      errs++; $display("FAIL soc_start: got %0d cycles expected 5", soc_rise_cyc - t0);
    end
    checks++;
    if (soc_pulses - p0 !== NS) begin
      errs++; $display("FAIL soc_pulses: got %0d expected %0d", soc_pulses - p0, NS);
    end
    checks++;
    if (soc_hi - h0 !== 2 * NS) begin
      errs++; $display("FAIL soc_width: got %0d expected %0d", soc_hi - h0, 2 * NS);
    end
    rib_rd(8'h20, d);
    checks++;
    if (d !== 32'h8000_0ABC) begin
      errs++; $display("FAIL result0: got %h expected 80000abc", d);
    end
    rib_rd(8'h04, d);
    checks++;
    if (d !== 32'h2) begin
      errs++; $display("FAIL single_status: got %h expected 00000002", d);
    end
    rib_rd(8'h20, d);
    checks++;
    if (d !== 32'h0000_0ABC) begin
      errs++; $display("FAIL fresh_clear: got %h expected 00000abc", d);
    end
  endtask

  task automatic test_multi_scan();
    logic [31:0] d;
    bit to;
    rib_wr(8'h04, 32'h6, 4'hF);
    repeat (NS) samples.push_back(12'h111);
    repeat (NS) samples.push_back(12'h222);
    repeat (NS) samples.push_back(12'h777);
    s_log.delete();
    rib_wr(8'h00, 32'h0000_8501, 4'hF);
    to = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge i_clk);
      if (s_log.size() >= 2 * NS + 1) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin
      errs++; $display("FAIL scan_timeout: channel 7 never started");
    end
    rib_rd(8'h04, d);
    checks++;
    if (d !== 32'h1) begin
      errs++; $display("FAIL done_early: got %h expected 00000001", d);
    end
    wait_idle(200, to);
    checks++;
    if (to) begin
      errs++; $display("FAIL scan_idle_timeout: busy never cleared");
    end
    checks++;
    if (s_log.size() != 3 * NS || s_log[0] !== 3'd0 || s_log[NS] !== 3'd2 || s_log[2 * NS] !== 3'd7) begin
      errs++; $display("FAIL chan_seq: got %0d entries expected 0,2,7", s_log.size());
    end
    rib_rd(8'h04, d);
    checks++;
    if (d !== 32'h2) begin
      errs++; $display("FAIL scan_status: got %h expected 00000002", d);
    end
    rib_rd(8'h20, d);
    checks++;
    if (d !== 32'h8000_0111) begin
      errs++; $display("FAIL result0_scan: got %h expected 80000111", d);
    end
    rib_rd(8'h28, d);
    checks++;
    if (d !== 32'h8000_0222) begin
      errs++; $display("FAIL result2: got %h expected 80000222", d);
    end
    rib_rd(8'h3C, d);
    checks++;
    if (d !== 32'h8000_0777) begin
      errs++; $display("FAIL result7: got %h expected 80000777", d);
    end
  endtask

  task automatic test_cont_ovr();
    logic [31:0] d;
    bit to;
    rib_wr(8'h04, 32'h6, 4'hF);
    rib_wr(8'h00, 32'h0000_0103, 4'hF);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rib_rd(8'h04, d);
      if (d[2]) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin
      errs++; $display("FAIL ovr_timeout: OVR never set");
    end
    checks++;
    if (d[2:1] !== 2'b11) begin
      errs++; $display("FAIL cont_status: got %b expected 11", d[2:1]);
    end
    rib_wr(8'h00, 32'h0000_0100, 4'hF);
    wait_idle(200, to);
    checks++;
    if (to) begin
      errs++; $display("FAIL cont_stop_timeout: busy never cleared");
    end
    rib_wr(8'h04, 32'h6, 4'hF);
    rib_rd(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL w1c: got %h expected 00000000", d);
    end
  endtask

  task automatic test_empty_mask();
    logic [31:0] d;
    int p0;
    p0 = soc_pulses;
    rib_wr(8'h00, 32'h0000_0001, 4'hF);
    repeat (20) @(negedge i_clk);
    checks++;
    if (soc_pulses !== p0) begin
      errs++; $display("FAIL empty_mask_soc: got %0d pulses expected 0", soc_pulses - p0);
    end
    rib_rd(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL empty_mask_status: got %h expected 00000000", d);
    end
    rib_rd(8'h00, d);
    checks++;
    if (d !== 32'h1) begin
      errs++; $display("FAIL empty_mask_ctrl: got %h expected 00000001", d);
    end
    rib_wr(8'h00, 32'h0, 4'hF);
  endtask

  task automatic test_byte_mask();
    logic [31:0] d;
    rib_wr(8'h00, 32'hFFFF_FF00, 4'b0010);
    rib_rd(8'h00, d);
    checks++;
    if (d !== 32'h0000_FF00) begin
      errs++; $display("FAIL ctrl_byte1: got %h expected 0000ff00", d);
    end
    rib_wr(8'h00, 32'h0000_0002, 4'b0001);
    rib_wr(8'h00, 32'hFFFF_FFFF, 4'b1100);
    rib_rd(8'h00, d);
    checks++;
    if (d !== 32'h0000_FF02) begin
      errs++; $display("FAIL ctrl_byte0: got %h expected 0000ff02", d);
    end
    rib_wr(8'h00, 32'h0, 4'hF);
    rib_wr(8'h08, 32'hFFFF_FFFF, 4'hF);
    rib_rd(8'h10, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL unmapped: got %h expected 00000000", d);
    end
  endtask

  task automatic test_en_clear();
    logic [31:0] d;
    int p0;
    bit to;
    repeat (NS) samples.push_back(12'h5A5);
    p0 = soc_pulses;
    rib_wr(8'h00, 32'h0000_0201, 4'hF);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_adc_soc) begin to = 1'b0; break; end
    end
    // drop EN while SOC is still high
    i_ribs_req = 1'b1; i_ribs_wrcs = 1'b1; i_ribs_addr = 32'h0;
    i_ribs_wdata = 32'h0000_0200; i_ribs_mask = 4'hF;
    #1;
    checks++;
    if (o_ribs_gnt !== 1'b1 || to) begin
      errs++; $display("FAIL gnt_or_soc: gnt %b soc_timeout %b expected 1 0", o_ribs_gnt, to);
    end
    @(negedge i_clk);
    i_ribs_req = 1'b0; i_ribs_wrcs = 1'b0;
    #1;
    checks++;
    if (o_ribs_gnt !== 1'b0) begin
      errs++; $display("FAIL gnt_low: got %b expected 0", o_ribs_gnt);
    end
    wait_idle(200, to);
    checks++;
    if (to) begin
      errs++; $display("FAIL en_clear_timeout: busy never cleared");
    end
    rib_rd(8'h24, d);
    checks++;
    if (d !== 32'h8000_05A5) begin
      errs++; $display("FAIL en_clear_result: got %h expected 800005a5", d);
    end
    rib_rd(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL en_clear_status: got %h expected 00000000", d);
    end
    checks++;
    if (soc_pulses - p0 !== NS) begin
      errs++; $display("FAIL en_clear_pulses: got %0d expected %0d", soc_pulses - p0, NS);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] d;
    int p0;
    bit to;
    p0 = soc_pulses;
    rib_wr(8'h00, 32'h0000_0201, 4'hF);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (soc_pulses > p0 && !o_adc_soc) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin
      errs++; $display("FAIL rst_wait_timeout: never reached WAIT");
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checks++;
    if ({o_adc_soc, o_adc_s} !== 4'b0) begin
      errs++; $display("FAIL rst_mid: got %b expected 0000", {o_adc_soc, o_adc_s});
    end
    repeat (30) @(negedge i_clk);
    rib_rd(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL rst_status: got %h expected 00000000", d);
    end
    rib_rd(8'h24, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL rst_result1: got %h expected 00000000", d);
    end
    rib_rd(8'h20, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL rst_result0: got %h expected 00000000", d);
    end
  endtask

`ifdef ADC_SCAN_AVG_EN
  task automatic test_average();
    logic [31:0] d;
    int p0;
    bit to;
    samples.push_back(12'h100); samples.push_back(12'h102);
    samples.push_back(12'h104); samples.push_back(12'h106);
    p0 = soc_pulses;
    rib_wr(8'h00, 32'h0000_0101, 4'hF);
    wait_idle(200, to);
    checks++;
    if (to) begin
      errs++; $display("FAIL avg_timeout: busy never cleared");
    end
    rib_rd(8'h20, d);
    checks++;
    if (d !== 32'h8000_0103) begin
      errs++; $display("FAIL avg_result: got %h expected 80000103", d);
    end
    checks++;
    if (soc_pulses - p0 !== 4) begin
      errs++; $display("FAIL avg_pulses: got %0d expected 4", soc_pulses - p0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_channel();
    test_multi_scan();
    test_cont_ovr();
    test_empty_mask();
    test_byte_mask();
    test_en_clear();
    test_reset_in_wait();
`ifdef ADC_SCAN_AVG_EN
    test_average();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
